// File: rtl/dataframe_merger_pkg.sv
// dataframe_merger_pkg: shared widths, defaults and FSM state encoding for the dataframe merger
package dataframe_merger_pkg;
    localparam int RFDC_TDATA_WIDTH     = 128;
    localparam int DEFAULT_FRAME_LENGTH = 512;
    localparam int FRAME_COUNT_WIDTH    = 32;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_t;
endpackage

// File: rtl/dataframe_merger_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr+1 (mod N)
// ports: req mask, ptr last-served index -> grant_oh one-hot, grant_idx index, any_req
module rr_arbiter #(
    parameter int N     = 8,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_oh,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_req
);
    always_comb begin
        int j;
        grant_idx = '0;
        // walk offsets from farthest to nearest so the nearest request wins
        for (int i = N; i >= 1; i--) begin
            j = (int'(ptr) + i) % N;
            if (req[j]) grant_idx = IDX_W'(j);
        end
        any_req  = |req;
        grant_oh = any_req ? N'(1) << grant_idx : '0;
    end
endmodule

// File: rtl/dataframe_merger.sv
// dataframe_merger: merges N_CHANNEL dataframe AXI-Streams into one, round-robin at frame boundaries
// ports: ACLK/ARESET (async, active-low); SET_CONFIG loads MAX_FRAME_LENGTH and CHANNEL_ENABLE in IDLE;
// S_AXIS_* per-channel inputs; M_AXIS_* merged output with TID = source channel;
// FRAME_COUNT counts output frames; MERGER_ERROR is sticky on truncation
module dataframe_merger
    import dataframe_merger_pkg::*;
#(
    parameter int N_CHANNEL   = 8,
    parameter int DATA_WIDTH  = RFDC_TDATA_WIDTH,
    parameter int CH_ID_WIDTH = 4,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            SET_CONFIG,
    input  logic [LEN_WIDTH-1:0]            MAX_FRAME_LENGTH,
    input  logic [N_CHANNEL-1:0]            CHANNEL_ENABLE,
    input  logic [N_CHANNEL*DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [N_CHANNEL-1:0]            S_AXIS_TVALID,
    input  logic [N_CHANNEL-1:0]            S_AXIS_TLAST,
    output logic [N_CHANNEL-1:0]            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    output logic [CH_ID_WIDTH-1:0]          M_AXIS_TID,
    input  logic                            M_AXIS_TREADY,
    output logic [FRAME_COUNT_WIDTH-1:0]    FRAME_COUNT,
    output logic                            MERGER_ERROR
);
    state_t                 state;
    logic [CH_ID_WIDTH-1:0] ptr;
    logic [CH_ID_WIDTH-1:0] grant;
    logic [N_CHANNEL-1:0]   grant_oh;
    logic [LEN_WIDTH-1:0]   cnt;
    logic [LEN_WIDTH-1:0]   max_len;
    logic [N_CHANNEL-1:0]   ch_en;
    logic [N_CHANNEL-1:0]   req;
    logic [N_CHANNEL-1:0]   arb_oh;
    logic [CH_ID_WIDTH-1:0] arb_idx;
    logic                   arb_any;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   ready_g;
    logic                   hs;
    logic [LEN_WIDTH-1:0]   cnt_next;
    logic [LEN_WIDTH-1:0]   max_eff;
    logic                   cut;

    always_comb begin
        // a config strobe in IDLE takes effect on the arbitration of the same cycle
        req       = S_AXIS_TVALID & (SET_CONFIG ? CHANNEL_ENABLE : ch_en);
        sel_valid = S_AXIS_TVALID[grant];
        sel_last  = S_AXIS_TLAST[grant];
        sel_data  = S_AXIS_TDATA[grant*DATA_WIDTH +: DATA_WIDTH];
        ready_g   = (state == STREAM) ? (!M_AXIS_TVALID || M_AXIS_TREADY) : (state == DROP);
        hs        = ready_g && sel_valid;
        S_AXIS_TREADY = ready_g ? grant_oh : '0;
        cnt_next  = cnt + LEN_WIDTH'(1);
        max_eff   = (max_len == '0) ? LEN_WIDTH'(1) : max_len;
        cut       = !sel_last && (cnt_next == max_eff);
    end

    rr_arbiter #(.N(N_CHANNEL), .IDX_W(CH_ID_WIDTH)) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state         <= IDLE;
            ptr           <= '0;
            grant         <= '0;
            grant_oh      <= '0;
            cnt           <= '0;
            max_len       <= LEN_WIDTH'(DEFAULT_FRAME_LENGTH);
            ch_en         <= '1;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TID    <= '0;
            FRAME_COUNT   <= '0;
            MERGER_ERROR  <= 1'b0;
        end else begin
            if (M_AXIS_TREADY) M_AXIS_TVALID <= 1'b0;
            if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST) FRAME_COUNT <= FRAME_COUNT + 1'b1;
            case (state)
                IDLE: begin
                    if (SET_CONFIG) begin
                        max_len <= MAX_FRAME_LENGTH;
                        ch_en   <= CHANNEL_ENABLE;
                    end
                    if (arb_any) begin
                        grant    <= arb_idx;
                        grant_oh <= arb_oh;
                        cnt      <= '0;
                        state    <= STREAM;
                    end
                end
                STREAM: if (hs) begin
                    M_AXIS_TDATA  <= sel_data;
                    M_AXIS_TLAST  <= sel_last || cut;
                    M_AXIS_TID    <= grant;
                    M_AXIS_TVALID <= 1'b1;
                    cnt           <= cnt_next;
                    if (sel_last) begin
                        ptr   <= grant;
                        state <= IDLE;
                    end else if (cut) begin
                        MERGER_ERROR <= 1'b1;
                        state        <= DROP;
                    end
                end
                DROP: if (hs && sel_last) begin
                    ptr   <= grant;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dataframe_merger.sv
// tb_dataframe_merger: scoreboard bench with directed frames for dataframe_merger
module tb_dataframe_merger;
    localparam int N  = 8;
    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [3:0]    id;
    } beat_t;

    logic            ACLK;
    logic            ARESET;
    logic            SET_CONFIG;
    logic [15:0]     MAX_FRAME_LENGTH;
    logic [N-1:0]    CHANNEL_ENABLE;
    logic [N*DW-1:0] S_AXIS_TDATA;
    logic [N-1:0]    S_AXIS_TVALID;
    logic [N-1:0]    S_AXIS_TLAST;
    logic [N-1:0]    S_AXIS_TREADY;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic            M_AXIS_TVALID;
    logic            M_AXIS_TLAST;
    logic [3:0]      M_AXIS_TID;
    logic            M_AXIS_TREADY;
    logic [31:0]     FRAME_COUNT;
    logic            MERGER_ERROR;

    dataframe_merger #(.N_CHANNEL(N), .DATA_WIDTH(DW), .CH_ID_WIDTH(4), .LEN_WIDTH(16)) dut (
        .ACLK             (ACLK),
        .ARESET           (ARESET),
        .SET_CONFIG       (SET_CONFIG),
        .MAX_FRAME_LENGTH (MAX_FRAME_LENGTH),
        .CHANNEL_ENABLE   (CHANNEL_ENABLE),
        .S_AXIS_TDATA     (S_AXIS_TDATA),
        .S_AXIS_TVALID    (S_AXIS_TVALID),
        .S_AXIS_TLAST     (S_AXIS_TLAST),
        .S_AXIS_TREADY    (S_AXIS_TREADY),
        .M_AXIS_TDATA     (M_AXIS_TDATA),
        .M_AXIS_TVALID    (M_AXIS_TVALID),
        .M_AXIS_TLAST     (M_AXIS_TLAST),
        .M_AXIS_TID       (M_AXIS_TID),
        .M_AXIS_TREADY    (M_AXIS_TREADY),
        .FRAME_COUNT      (FRAME_COUNT),
        .MERGER_ERROR     (MERGER_ERROR)
    );

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_q[$];
    logic [DW:0] src_mem [N][64];
    int          src_wr [N];
    int          src_rd [N];
    int          flush_req = 0;
    bit          toggle_en = 0;
    bit          tready_fix = 1;
    bit          gap_en = 0;
    bit          stall_en = 0;
    bit          ch0_watch = 0;

    initial begin
        ACLK = 0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input bit ok, input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load(input int ch, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            src_mem[ch][src_wr[ch]] = {i == n - 1, base + DW'(i)};
            src_wr[ch]++;
        end
    endtask

    task automatic expect_frame(input int ch, input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) exp_q.push_back('{d: base + DW'(i), l: i == n - 1, id: 4'(ch)});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge ACLK);
        chk(exp_q.size() == 0, "drain_timeout", 136'(exp_q.size()), 136'(0));
        repeat (6) @(negedge ACLK);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // source driver and M_AXIS_TREADY pattern; advances each source on a handshake seen mid-cycle
    initial begin
        logic [N-1:0] taken;
        int           flush_seen;
        flush_seen    = 0;
        S_AXIS_TVALID = '0;
        S_AXIS_TLAST  = '0;
        S_AXIS_TDATA  = '0;
        M_AXIS_TREADY = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_wr[k] = 0;
            src_rd[k] = 0;
        end
        forever begin
            @(negedge ACLK);
            taken = S_AXIS_TVALID & S_AXIS_TREADY;
            @(posedge ACLK);
            #1;
            for (int k = 0; k < N; k++) if (taken[k]) src_rd[k]++;
            if (flush_seen != flush_req) begin
                flush_seen = flush_req;
                for (int k = 0; k < N; k++) src_rd[k] = src_wr[k];
            end
            for (int k = 0; k < N; k++) begin
                S_AXIS_TVALID[k]          = src_rd[k] < src_wr[k];
                S_AXIS_TLAST[k]           = S_AXIS_TVALID[k] ? src_mem[k][src_rd[k]][DW] : 1'b0;
                S_AXIS_TDATA[k*DW +: DW]  = S_AXIS_TVALID[k] ? src_mem[k][src_rd[k]][DW-1:0] : '0;
            end
            M_AXIS_TREADY = toggle_en ? !M_AXIS_TREADY : tready_fix;
        end
    end

    // monitor: scoreboard pops, stall stability, idle-gap and ready checks
    initial begin
        beat_t         e;
        int            cyc, last_cyc;
        bit            prev_v, prev_r, first, last_gap;
        logic [DW-1:0] prev_d;
        cyc = 0; last_cyc = 0; prev_v = 0; prev_r = 0; first = 1; last_gap = 0; prev_d = '0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (!ARESET) begin
                prev_v = 0;
                first  = 1;
            end else begin
                if (prev_v && !prev_r)
                    chk(M_AXIS_TVALID && M_AXIS_TDATA == prev_d, "stall_hold", 136'(M_AXIS_TDATA), 136'(prev_d));
                if (stall_en && M_AXIS_TVALID && !M_AXIS_TREADY)
                    chk(S_AXIS_TREADY == '0, "stall_sready", 136'(S_AXIS_TREADY), 136'(0));
                if (ch0_watch)
                    chk(!S_AXIS_TREADY[0], "ch0_ready", 136'(S_AXIS_TREADY[0]), 136'(0));
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_beat", {M_AXIS_TID, 3'b0, M_AXIS_TLAST, M_AXIS_TDATA}, 136'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk({M_AXIS_TID, M_AXIS_TLAST, M_AXIS_TDATA} == {e.id, e.l, e.d}, "beat",
                            {M_AXIS_TID, 3'b0, M_AXIS_TLAST, M_AXIS_TDATA}, {e.id, 3'b0, e.l, e.d});
                        if (gap_en && last_gap && first)
                            chk(cyc - last_cyc == 2, "frame_gap", 136'(cyc - last_cyc), 136'(2));
                        first = e.l;
                        if (e.l) begin
                            last_cyc = cyc;
                            last_gap = gap_en;
                        end
                    end
                end
                prev_v = M_AXIS_TVALID;
                prev_r = M_AXIS_TREADY;
                prev_d = M_AXIS_TDATA;
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TID, MERGER_ERROR} == '0, {name, "_ctrl"},
            136'({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TID, MERGER_ERROR}), 136'(0));
        chk(M_AXIS_TDATA == '0, {name, "_data"}, 136'(M_AXIS_TDATA), 136'(0));
        chk(FRAME_COUNT == 0, {name, "_fcount"}, 136'(FRAME_COUNT), 136'(0));
        chk(S_AXIS_TREADY == '0, {name, "_sready"}, 136'(S_AXIS_TREADY), 136'(0));
    endtask

    task automatic do_reset();
        ARESET = 1'b0;
        flush_req++;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    initial begin
        bit seen;
        ARESET = 1'b0;
        SET_CONFIG = 1'b0;
        MAX_FRAME_LENGTH = '0;
        CHANNEL_ENABLE = '0;
        repeat (3) @(negedge ACLK);
        check_all_zero("reset");
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);

        // single channel 2, 4 words, with 1-cycle latency from first handshake
        tick();
        load(2, 4, 128'h200);
        expect_frame(2, 4, 128'h200);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            seen = S_AXIS_TVALID[2] && S_AXIS_TREADY[2];
        end
        chk(seen, "t1_handshake", 136'(seen), 136'(1));
        @(negedge ACLK);
        chk(M_AXIS_TVALID && M_AXIS_TDATA == 128'h200, "t1_latency", {7'b0, M_AXIS_TVALID, M_AXIS_TDATA}, {8'h01, 128'h200});
        wait_drain();
        chk(FRAME_COUNT == 1, "t1_fcount", 136'(FRAME_COUNT), 136'(1));

        // channels 0, 1, 3 ready together from pointer 0: order 1, 3, 0 with one idle cycle between frames
        do_reset();
        gap_en = 1;
        tick();
        load(0, 3, 128'h010);
        load(1, 3, 128'h100);
        load(3, 3, 128'h300);
        expect_frame(1, 3, 128'h100);
        expect_frame(3, 3, 128'h300);
        expect_frame(0, 3, 128'h010);
        wait_drain();
        gap_en = 0;
        chk(FRAME_COUNT == 3, "t2_fcount", 136'(FRAME_COUNT), 136'(3));
        chk(MERGER_ERROR == 0, "t2_error", 136'(MERGER_ERROR), 136'(0));

        // max length 4, channel 5 sends 7 words: 4 out, tail dropped, error set
        tick();
        SET_CONFIG = 1'b1;
        MAX_FRAME_LENGTH = 16'd4;
        CHANNEL_ENABLE = '1;
        tick();
        SET_CONFIG = 1'b0;
        load(5, 7, 128'h500);
        expect_frame(5, 4, 128'h500);
        wait_drain();
        chk(MERGER_ERROR == 1, "t3_error", 136'(MERGER_ERROR), 136'(1));
        chk(FRAME_COUNT == 4, "t3_fcount", 136'(FRAME_COUNT), 136'(4));
        chk(src_rd[5] == src_wr[5], "t3_dropped", 136'(src_wr[5] - src_rd[5]), 136'(0));
        tick();
        SET_CONFIG = 1'b1;
        MAX_FRAME_LENGTH = 16'd512;
        tick();
        SET_CONFIG = 1'b0;

        // output ready toggling during a 6-word frame
        stall_en = 1;
        toggle_en = 1;
        load(4, 6, 128'h400);
        expect_frame(4, 6, 128'h400);
        wait_drain();
        toggle_en = 0;
        stall_en = 0;
        tready_fix = 1;
        chk(FRAME_COUNT == 5, "t4_fcount", 136'(FRAME_COUNT), 136'(5));

        // channel 0 disabled while both 0 and 1 are valid
        repeat (2) tick();
        ch0_watch = 1;
        SET_CONFIG = 1'b1;
        CHANNEL_ENABLE = 8'b1111_1110;
        load(0, 3, 128'h1000);
        load(1, 3, 128'h1100);
        expect_frame(1, 3, 128'h1100);
        tick();
        SET_CONFIG = 1'b0;
        wait_drain();
        ch0_watch = 0;
        chk(src_wr[0] - src_rd[0] == 3, "t5_ch0_held", 136'(src_wr[0] - src_rd[0]), 136'(3));
        chk(FRAME_COUNT == 6, "t5_fcount", 136'(FRAME_COUNT), 136'(6));

        // asynchronous reset in the middle of a stalled frame
        tready_fix = 0;
        load(6, 8, 128'h600);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge ACLK);
            seen = M_AXIS_TVALID;
        end
        chk(seen && MERGER_ERROR, "t6_pre_reset", 136'({seen, MERGER_ERROR}), 136'(3));
        #2;
        ARESET = 1'b0;
        #1;
        check_all_zero("t6_async");
        flush_req++;
        tready_fix = 1;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        check_all_zero("t6_release");
        tick();
        load(3, 2, 128'h700);
        expect_frame(3, 2, 128'h700);
        wait_drain();
        chk(FRAME_COUNT == 1, "t6_fcount", 136'(FRAME_COUNT), 136'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
